mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store initiator that drives the word-organised data memory on behalf of the MIPS32 datapath. It accepts one load/store request at a time and issues read/write strobes, word address and write data to the memory. It returns sign- or zero-extended load data. Byte and halfword stores are built as read-modify-write sequences because the memory only supports whole 32-bit words.

Parameters:
MEM_WORDS, 8192, number of 32-bit words in the data memory; word index = address>>2
ADDR_W, 32, byte-address width
DATA_W, 32, data width; fixed at 32, any other value unsupported

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  1  request strobe; sampled only in IDLE
op  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW
addr  in  32  byte address of request
wdata  in  32  store data; SB uses [7:0], SH uses [15:0]
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; misaligned or out-of-range request
rdata  out  32  extended load result; updated only by a successful load
readEn  out  1  memory read strobe
writeEn  out  1  memory write strobe
address  out  32  memory byte address, low two bits always 00
dataIn  out  32  memory write data
dataOut  in  32  memory read data, registered by memory on the readEn edge

Behaviour:
- Reset, synchronous: state=IDLE; busy, done, err, readEn, writeEn = 0; address, dataIn, rdata = 0.
- Byte order is little-endian. Byte k sits at bits [8k+7:8k] with k=addr[1:0]. The halfword sits at bits [16h+15:16h] with h=addr[1].
- IDLE: on req=1, latch op, addr and wdata, and drive address={addr[31:2],2'b00}. address holds stable until the next accept.
  - err case: halfword op with addr[0]=1, word op with addr[1:0]!=0, or (addr>>2)>=MEM_WORDS. Go to DONE with err=1. No strobe is ever asserted.
  - Otherwise, LB/LBU/LH/LHU/LW/SB/SH go to RD and SW goes to WR.
- RD: readEn=1 for exactly one cycle -> RESP.
- RESP: dataOut is valid.
  - Loads: rdata <= extracted lane, sign-extended for LB/LH, zero-extended for LBU/LHU/LW -> DONE.
  - SB/SH: merge word <= dataOut with the target lane replaced by wdata -> WR.
- WR: writeEn=1 for exactly one cycle. dataIn = merge word for SB/SH, wdata for SW -> DONE.
- DONE: done=1 for one cycle. err=1 only for rejected requests. -> IDLE.
- readEn and writeEn are never high together. Both are Moore outputs decoded from state.
- Latency, accept edge to done high: SW 2 cycles, loads 3 cycles, SB/SH 4 cycles, err 1 cycle.
- req outside IDLE is ignored and never queued. The next req is accepted in the first IDLE cycle after DONE.
- Reset mid-operation: if reset is sampled on the WR edge, that write completes because writeEn is already high. Otherwise no further strobes are issued, the FSM returns to IDLE, and no done pulse is produced.
- rdata holds its value across stores and errors.

Decomposition:
- mem_access_pkg:
  - op encodings (OP_LB..OP_SW)
  - state enum (IDLE, RD, RESP, WR, DONE)
  - MEM_WORDS default
  - lane-width constants
- Sub-module byte_lane_unit, purely combinational:
  - extract: word, addr[1:0], op -> extended rdata
  - merge: word, wdata, addr[1:0], op -> merged store word
  - Instantiated once in mem_access_unit.

Test Plan:
- Memory preloaded word[i]=i. LW addr=0x40 -> readEn pulses 1 cycle with address=0x40, rdata=0x00000010, done 3 cycles after accept, err=0.
- SB addr=0x41, wdata=0xAB -> read then write, dataIn=0x0000AB10, writeEn 1 cycle. Then LBU 0x41 -> 0x000000AB and LB 0x41 -> 0xFFFFFFAB.
- SH addr=0x46, wdata=0x8001 on word[17]=0x11 -> dataIn=0x80010011. Then LH 0x46 -> 0xFFFF8001 and LHU 0x46 -> 0x00008001.
- LW addr=0x42; LH addr=0x43; SW addr=0x8000 (word 8192) -> each gives done+err 1 cycle after accept, readEn/writeEn stay 0, rdata unchanged.
- SW 0x10 with req held high plus a second op toggled in during busy -> only one access issued. A new req in the IDLE cycle after done is accepted immediately.
- reset asserted during RESP of SB 0x41 -> writeEn never asserts, word[16] unchanged, all outputs 0 the next cycle, no done.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory load/store initiator: op codes,
// FSM states, memory geometry and lane widths.
package mem_access_pkg;

    localparam int unsigned WORD_W            = 32;
    localparam int unsigned HALF_W            = 16;
    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned LANE_W            = 2;
    localparam int unsigned OP_W              = 3;
    localparam int unsigned MEM_WORDS_DEFAULT = 8192;

    localparam logic [OP_W-1:0] OP_LB  = 3'd0;
    localparam logic [OP_W-1:0] OP_LBU = 3'd1;
    localparam logic [OP_W-1:0] OP_LH  = 3'd2;
    localparam logic [OP_W-1:0] OP_LHU = 3'd3;
    localparam logic [OP_W-1:0] OP_LW  = 3'd4;
    localparam logic [OP_W-1:0] OP_SB  = 3'd5;
    localparam logic [OP_W-1:0] OP_SH  = 3'd6;
    localparam logic [OP_W-1:0] OP_SW  = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RESP = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } stateT;

    // Loads occupy the low op codes, stores the high ones.
    function automatic logic isLoad(input logic [OP_W-1:0] op);
        return op <= OP_LW;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic for sub-word accesses (little-endian).
//   word      : 32-bit word read from memory
//   wdata     : store data (SB uses [7:0], SH uses [15:0])
//   lane      : byte address low bits
//   op        : access op code
//   loadData  : extracted, sign/zero-extended load result
//   mergeData : word with the store lane replaced (wdata for SW)
import mem_access_pkg::*;

module byte_lane_unit (
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [LANE_W-1:0] lane,
    input  logic [OP_W-1:0]   op,
    output logic [WORD_W-1:0] loadData,
    output logic [WORD_W-1:0] mergeData
);

    logic [BYTE_W-1:0] byteSel;
    logic [HALF_W-1:0] halfSel;

    // Extract the addressed byte/halfword and extend it.
    always_comb begin
        byteSel  = word[{lane, 3'b000} +: BYTE_W];
        halfSel  = word[{lane[1], 4'b0000} +: HALF_W];
        loadData = word;
        case (op)
            OP_LB:   loadData = {{(WORD_W-BYTE_W){byteSel[BYTE_W-1]}}, byteSel};
            OP_LBU:  loadData = {{(WORD_W-BYTE_W){1'b0}}, byteSel};
            OP_LH:   loadData = {{(WORD_W-HALF_W){halfSel[HALF_W-1]}}, halfSel};
            OP_LHU:  loadData = {{(WORD_W-HALF_W){1'b0}}, halfSel};
            default: loadData = word;
        endcase
    end

    // Replace the addressed lane with store data.
    always_comb begin
        mergeData = word;
        case (op)
            OP_SB:   mergeData[{lane, 3'b000} +: BYTE_W]    = wdata[BYTE_W-1:0];
            OP_SH:   mergeData[{lane[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            OP_SW:   mergeData = wdata;
            default: mergeData = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-organised data memory. One request at a
// time; byte/halfword stores are done as read-modify-write.
//   clk, reset          : clock, synchronous active-high reset
//   req, op, addr, wdata: request (sampled only in IDLE)
//   busy, done, err     : status; done is a one-cycle pulse, err valid with done
//   rdata               : extended load result, updated only by good loads
//   readEn, writeEn     : memory strobes
//   address, dataIn     : memory word-aligned byte address and write data
//   dataOut             : memory read data, registered on the readEn edge
import mem_access_pkg::*;

module mem_access_unit #(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              readEn,
    output logic              writeEn,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataIn,
    input  logic [DATA_W-1:0] dataOut
);

    stateT             state, nextState;
    logic [OP_W-1:0]   opQ;
    logic [LANE_W-1:0] laneQ;
    logic [DATA_W-1:0] wdataQ;
    logic              accept, reject, badReq;
    logic [DATA_W-1:0] loadData, mergeData;

    byte_lane_unit laneUnit (
        .word      (dataOut),
        .wdata     (wdataQ),
        .lane      (laneQ),
        .op        (opQ),
        .loadData  (loadData),
        .mergeData (mergeData)
    );

    // Alignment and range check on the incoming request.
    always_comb begin
        badReq = 1'b0;
        if ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0])
            badReq = 1'b1;
        if ((op == OP_LW || op == OP_SW) && (addr[1:0] != 2'b00))
            badReq = 1'b1;
        if ((addr >> 2) >= ADDR_W'(MEM_WORDS))
            badReq = 1'b1;
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (badReq) begin
                        reject    = 1'b1;
                        nextState = DONE;
                    end else if (op == OP_SW) begin
                        nextState = WR;
                    end else begin
                        nextState = RD;
                    end
                end
            end
            RD:      nextState = RESP;
            RESP:    nextState = isLoad(opQ) ? DONE : WR;
            WR:      nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State, request capture and registered (state-decoded) outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            readEn  <= 1'b0;
            writeEn <= 1'b0;
            address <= '0;
            dataIn  <= '0;
            rdata   <= '0;
            opQ     <= OP_LB;
            laneQ   <= '0;
            wdataQ  <= '0;
        end else begin
            state   <= nextState;
            busy    <= (nextState != IDLE);
            done    <= (nextState == DONE);
            err     <= reject;
            readEn  <= (nextState == RD);
            writeEn <= (nextState == WR);
            if (accept) begin
                opQ     <= op;
                laneQ   <= addr[1:0];
                wdataQ  <= wdata;
                address <= {addr[ADDR_W-1:2], 2'b00};
                // SW skips the read, so its write data comes straight in.
                if (nextState == WR)
                    dataIn <= wdata;
            end
            if (state == RESP) begin
                if (isLoad(opQ))
                    rdata  <= loadData;
                else
                    dataIn <= mergeData;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural
// word memory preloaded with word[i] = i.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err, readEn, writeEn;
    logic [31:0] rdata, address, dataIn, dataOut;

    logic [31:0] mem [0:8191];
    int readCnt = 0, writeCnt = 0, doneCnt = 0, bothHigh = 0;
    logic [31:0] lastReadAddr = '0, lastWriteData = '0;
    int nCmp = 0, nBad = 0;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    mem_access_unit dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .op      (op),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .readEn  (readEn),
        .writeEn (writeEn),
        .address (address),
        .dataIn  (dataIn),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    // Word memory: read data registered on the readEn edge.
    always @(posedge clk) begin
        if (readEn) begin
            dataOut      <= mem[address[14:2]];
            readCnt      <= readCnt + 1;
            lastReadAddr <= address;
        end
        if (writeEn) begin
            mem[address[14:2]] <= dataIn;
            writeCnt           <= writeCnt + 1;
            lastWriteData      <= dataIn;
        end
        if (done) doneCnt <= doneCnt + 1;
        if (readEn && writeEn) bothHigh <= bothHigh + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for done after an accept edge; returns cycles from accept to done.
    task automatic waitDone(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] w, input int expLat, input logic expErr,
                         input int expR, input int expW);
        int r0, w0, lat;
        waitIdle();
        r0 = readCnt; w0 = writeCnt;
        req = 1'b1; op = o; addr = a; wdata = w;
        @(posedge clk);
        #1;
        req = 1'b0;
        waitDone(lat);
        chk({tag, " latency"}, 32'(lat), 32'(expLat));
        chk({tag, " err"}, 32'(err), 32'(expErr));
        chk({tag, " reads"}, 32'(readCnt - r0), 32'(expR));
        chk({tag, " writes"}, 32'(writeCnt - w0), 32'(expW));
    endtask

    initial begin
        int lat, r0, w0, d0;
        for (int i = 0; i < 8192; i++) mem[i] = 32'(i);
        reset = 1'b1; req = 1'b0; op = LW; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset strobes", {30'd0, readEn, writeEn}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset address", address, 32'd0);
        chk("reset dataIn", dataIn, 32'd0);
        reset = 1'b0;

        runOp("LW 0x40", LW, 32'h40, 32'h0, 3, 1'b0, 1, 0);
        chk("LW 0x40 rdata", rdata, 32'h0000_0010);
        chk("LW 0x40 rd addr", lastReadAddr, 32'h40);

        runOp("SB 0x41", SB, 32'h41, 32'hAB, 4, 1'b0, 1, 1);
        chk("SB 0x41 dataIn", lastWriteData, 32'h0000_AB10);
        chk("SB 0x41 mem", mem[16], 32'h0000_AB10);
        chk("SB 0x41 address", address, 32'h40);
        runOp("LBU 0x41", LBU, 32'h41, 32'h0, 3, 1'b0, 1, 0);
        chk("LBU 0x41 rdata", rdata, 32'h0000_00AB);
        runOp("LB 0x41", LB, 32'h41, 32'h0, 3, 1'b0, 1, 0);
        chk("LB 0x41 rdata", rdata, 32'hFFFF_FFAB);

        runOp("SH 0x46", SH, 32'h46, 32'h8001, 4, 1'b0, 1, 1);
        chk("SH 0x46 dataIn", lastWriteData, 32'h8001_0011);
        runOp("LH 0x46", LH, 32'h46, 32'h0, 3, 1'b0, 1, 0);
        chk("LH 0x46 rdata", rdata, 32'hFFFF_8001);
        runOp("LHU 0x46", LHU, 32'h46, 32'h0, 3, 1'b0, 1, 0);
        chk("LHU 0x46 rdata", rdata, 32'h0000_8001);

        runOp("LW 0x42", LW, 32'h42, 32'h0, 1, 1'b1, 0, 0);
        chk("LW 0x42 rdata held", rdata, 32'h0000_8001);
        runOp("LH 0x43", LH, 32'h43, 32'h0, 1, 1'b1, 0, 0);
        runOp("SW 0x8000", SW, 32'h8000, 32'h1234_5678, 1, 1'b1, 0, 0);
        chk("SW 0x8000 rdata held", rdata, 32'h0000_8001);
        @(posedge clk);
        #1;
        chk("err clears", 32'(err), 32'd0);

        // req held high through a busy SW while op/addr change underneath.
        waitIdle();
        r0 = readCnt; w0 = writeCnt;
        req = 1'b1; op = SW; addr = 32'h10; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        op = LW; addr = 32'h20;
        waitDone(lat);
        chk("SW held latency", 32'(lat), 32'd2);
        chk("SW held writes", 32'(writeCnt - w0), 32'd1);
        chk("SW held reads", 32'(readCnt - r0), 32'd0);
        chk("SW held mem", mem[4], 32'hDEAD_BEEF);
        chk("SW held dataIn", lastWriteData, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        chk("idle after done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("next req accepted", {30'd0, busy, readEn}, 32'd3);
        req = 1'b0;
        waitDone(lat);
        chk("next req latency", 32'(lat), 32'd3);
        chk("next req rdata", rdata, 32'h0000_0008);
        chk("next req reads", 32'(readCnt - r0), 32'd1);

        // Reset sampled while the SB is in RESP.
        waitIdle();
        w0 = writeCnt; d0 = doneCnt;
        req = 1'b1; op = SB; addr = 32'h41; wdata = 32'h55;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst mid busy", 32'(busy), 32'd0);
        chk("rst mid flags", {29'd0, done, err, writeEn}, 32'd0);
        chk("rst mid readEn", 32'(readEn), 32'd0);
        chk("rst mid address", address, 32'd0);
        chk("rst mid rdata", rdata, 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst mid writes", 32'(writeCnt - w0), 32'd0);
        chk("rst mid no done", 32'(doneCnt - d0), 32'd0);
        chk("rst mid mem", mem[16], 32'h0000_AB10);
        chk("strobes exclusive", 32'(bothHigh), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
